// File: rtl/rv_decode_pkg.sv
`default_nettype none
// rv_decode_pkg: RV32 opcode/immediate-format encodings and the immediate decoder.
// Rev 1.0
package rv_decode_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [6:0] {
      OPC_LUI      = 7'b0110111,
      OPC_AUIPC    = 7'b0010111,
      OPC_JAL      = 7'b1101111,
      OPC_JALR     = 7'b1100111,
      OPC_BRANCH   = 7'b1100011,
      OPC_LOAD     = 7'b0000011,
      OPC_STORE    = 7'b0100011,
      OPC_OP_IMM   = 7'b0010011,
      OPC_OP       = 7'b0110011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_e;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   function automatic logic [31:0] decode_imm(input logic [31:0] ins, input imm_fmt_e fmt);
      logic [31:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   imm = {ins[31:12], 12'b0};
         IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// decode_regfile: NREG x XLEN register file, two async read ports, one write port, x0 hardwired to 0.
// Rev 1.0
module decode_regfile
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [XLEN-1:0]       rdata1,
   output logic [XLEN-1:0]       rdata2,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] regs [NREG];

   function automatic logic live(input logic [REG_ADDR_W-1:0] a);
      return (a != '0) && (32'(a) < 32'(NREG));
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && live(waddr)) begin
         regs[waddr[AW-1:0]] <= wdata;
      end
   end

   assign rdata1 = live(raddr1) ? regs[raddr1[AW-1:0]] : '0;
   assign rdata2 = live(raddr2) ? regs[raddr2[AW-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// decode_stage: RV32 decode with registered decode->execute boundary, regfile and RAW/WAW scoreboard.
// Rev 1.0 -- define DECODE_WB_BYPASS_EN to forward write-back data into the decoding operands.
module decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_if_valid,
   output logic                  o_if_ready,
   input  logic [XLEN-1:0]       i_if_instr,
   input  logic [XLEN-1:0]       i_if_pc,
   output logic                  o_ex_valid,
   input  logic                  i_ex_ready,
   output logic [XLEN-1:0]       o_ex_pc,
   output logic [6:0]            o_ex_opcode,
   output logic [2:0]            o_ex_funct3,
   output logic [6:0]            o_ex_funct7,
   output logic [XLEN-1:0]       o_ex_imm,
   output logic [XLEN-1:0]       o_ex_rs1_rdata,
   output logic [XLEN-1:0]       o_ex_rs2_rdata,
   output logic [REG_ADDR_W-1:0] o_ex_rd_waddr,
   output logic                  o_ex_rd_wen,
   output logic                  o_ex_illegal,
   input  logic                  i_wb_valid,
   input  logic [REG_ADDR_W-1:0] i_wb_waddr,
   input  logic [XLEN-1:0]       i_wb_wdata,
   input  logic                  i_flush,
   output logic                  o_dbg_stall
);

   localparam int AW = $clog2(NREG);

   function automatic logic in_range(input logic [REG_ADDR_W-1:0] a);
      return 32'(a) < 32'(NREG);
   endfunction

   opcode_e               opc;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   logic                  known, used_rs1, used_rs2, wr_class;
   imm_fmt_e              fmt;

   assign opc = opcode_e'(i_if_instr[6:0]);
   assign rs1 = i_if_instr[19:15];
   assign rs2 = i_if_instr[24:20];
   assign rd  = i_if_instr[11:7];

   always_comb begin
      known    = 1'b1;
      used_rs1 = 1'b1;
      used_rs2 = 1'b0;
      wr_class = 1'b0;
      fmt      = IMM_NONE;
      case (opc)
         OPC_LUI:      begin used_rs1 = 1'b0; wr_class = 1'b1; fmt = IMM_U; end
         OPC_AUIPC:    begin used_rs1 = 1'b0; wr_class = 1'b1; fmt = IMM_U; end
         OPC_JAL:      begin used_rs1 = 1'b0; wr_class = 1'b1; fmt = IMM_J; end
         OPC_JALR:     begin wr_class = 1'b1; fmt = IMM_I; end
         OPC_BRANCH:   begin used_rs2 = 1'b1; fmt = IMM_B; end
         OPC_LOAD:     begin wr_class = 1'b1; fmt = IMM_I; end
         OPC_STORE:    begin used_rs2 = 1'b1; fmt = IMM_S; end
         OPC_OP_IMM:   begin wr_class = 1'b1; fmt = IMM_I; end
         OPC_OP:       begin used_rs2 = 1'b1; wr_class = 1'b1; end
         OPC_MISC_MEM: fmt = IMM_I;
         OPC_SYSTEM:   fmt = IMM_I;
         default:      begin known = 1'b0; used_rs1 = 1'b0; end
      endcase
   end

   logic rs1_in, rs2_in, rd_in, wen, sb_set_ok, illegal;
   assign rs1_in    = in_range(rs1);
   assign rs2_in    = in_range(rs2);
   assign rd_in     = in_range(rd);
   assign wen       = wr_class & (rd != '0);
   assign sb_set_ok = wen & rd_in;
   assign illegal   = ~known | (used_rs1 & ~rs1_in) | (used_rs2 & ~rs2_in) | (wr_class & ~rd_in);

   logic src1_live, src2_live, byp1, byp2;
   assign src1_live = used_rs1 & (rs1 != '0) & rs1_in;
   assign src2_live = used_rs2 & (rs2 != '0) & rs2_in;
`ifdef DECODE_WB_BYPASS_EN
   assign byp1 = i_wb_valid & src1_live & (i_wb_waddr == rs1);
   assign byp2 = i_wb_valid & src2_live & (i_wb_waddr == rs2);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   logic [NREG-1:0] sb, sb_next;
   logic            hazard, slot_free, fire_in, fire_out, held_sb;

   assign hazard = i_if_valid & ((src1_live & sb[rs1[AW-1:0]] & ~byp1) |
                                 (src2_live & sb[rs2[AW-1:0]] & ~byp2) |
                                 (sb_set_ok & sb[rd[AW-1:0]]));

   assign slot_free   = ~o_ex_valid | i_ex_ready;
   assign o_if_ready  = slot_free & ~hazard & ~i_flush;
   assign fire_in     = i_if_valid & o_if_ready;
   assign fire_out    = o_ex_valid & i_ex_ready;
   assign o_dbg_stall = hazard & slot_free;

   logic [XLEN-1:0] rf_rd1, rf_rd2;

   decode_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rf_rd1),
      .rdata2 (rf_rd2),
      .we     (i_wb_valid),
      .waddr  (i_wb_waddr),
      .wdata  (i_wb_wdata)
   );

   // Set beats clear so a write-back to the rd just being issued cannot release it.
   always_comb begin
      sb_next = sb;
      if (i_wb_valid && in_range(i_wb_waddr)) sb_next[i_wb_waddr[AW-1:0]] = 1'b0;
      if (i_flush && o_ex_valid && !fire_out && held_sb) sb_next[o_ex_rd_waddr[AW-1:0]] = 1'b0;
      if (fire_in && sb_set_ok) sb_next[rd[AW-1:0]] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sb <= '0;
      else     sb <= sb_next;
   end

   logic signed [31:0] imm32;
   assign imm32 = decode_imm(i_if_instr[31:0], fmt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_ex_valid     <= 1'b0;
         o_ex_pc        <= '0;
         o_ex_opcode    <= '0;
         o_ex_funct3    <= '0;
         o_ex_funct7    <= '0;
         o_ex_imm       <= '0;
         o_ex_rs1_rdata <= '0;
         o_ex_rs2_rdata <= '0;
         o_ex_rd_waddr  <= '0;
         o_ex_rd_wen    <= 1'b0;
         o_ex_illegal   <= 1'b0;
         held_sb        <= 1'b0;
      end else if (i_flush) begin
         o_ex_valid <= 1'b0;
         held_sb    <= 1'b0;
      end else if (slot_free) begin
         o_ex_valid <= fire_in;
         if (fire_in) begin
            o_ex_pc        <= i_if_pc;
            o_ex_opcode    <= i_if_instr[6:0];
            o_ex_funct3    <= i_if_instr[14:12];
            o_ex_funct7    <= i_if_instr[31:25];
            o_ex_imm       <= XLEN'(imm32);
            o_ex_rs1_rdata <= byp1 ? i_wb_wdata : rf_rd1;
            o_ex_rs2_rdata <= byp2 ? i_wb_wdata : rf_rd2;
            o_ex_rd_waddr  <= rd;
            o_ex_rd_wen    <= wen;
            o_ex_illegal   <= illegal;
            held_sb        <= sb_set_ok;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// tb_decode_stage: table-driven check of decode_stage (RV32I instance) plus an RV32E instance.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        if_valid, if_ready, ex_valid, ex_ready, rd_wen, illegal;
   logic        wb_valid, flush, stall;
   logic [31:0] if_instr, if_pc, ex_pc, ex_imm, rs1_d, rs2_d, wb_wdata;
   logic [6:0]  ex_opcode, ex_funct7;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd, wb_waddr;

   decode_stage #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst(rst),
      .i_if_valid(if_valid), .o_if_ready(if_ready), .i_if_instr(if_instr), .i_if_pc(if_pc),
      .o_ex_valid(ex_valid), .i_ex_ready(ex_ready), .o_ex_pc(ex_pc),
      .o_ex_opcode(ex_opcode), .o_ex_funct3(ex_funct3), .o_ex_funct7(ex_funct7),
      .o_ex_imm(ex_imm), .o_ex_rs1_rdata(rs1_d), .o_ex_rs2_rdata(rs2_d),
      .o_ex_rd_waddr(ex_rd), .o_ex_rd_wen(rd_wen), .o_ex_illegal(illegal),
      .i_wb_valid(wb_valid), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
      .i_flush(flush), .o_dbg_stall(stall)
   );

   logic        e_if_valid, e_if_ready, e_ex_valid, e_ex_ready, e_rd_wen, e_illegal;
   logic        e_wb_valid, e_flush, e_stall;
   logic [31:0] e_if_instr, e_if_pc, e_ex_pc, e_ex_imm, e_rs1_d, e_rs2_d, e_wb_wdata;
   logic [6:0]  e_ex_opcode, e_ex_funct7;
   logic [2:0]  e_ex_funct3;
   logic [4:0]  e_ex_rd, e_wb_waddr;

   decode_stage #(.XLEN(32), .NREG(16)) dut_e (
      .clk(clk), .rst(rst),
      .i_if_valid(e_if_valid), .o_if_ready(e_if_ready), .i_if_instr(e_if_instr), .i_if_pc(e_if_pc),
      .o_ex_valid(e_ex_valid), .i_ex_ready(e_ex_ready), .o_ex_pc(e_ex_pc),
      .o_ex_opcode(e_ex_opcode), .o_ex_funct3(e_ex_funct3), .o_ex_funct7(e_ex_funct7),
      .o_ex_imm(e_ex_imm), .o_ex_rs1_rdata(e_rs1_d), .o_ex_rs2_rdata(e_rs2_d),
      .o_ex_rd_waddr(e_ex_rd), .o_ex_rd_wen(e_rd_wen), .o_ex_illegal(e_illegal),
      .i_wb_valid(e_wb_valid), .i_wb_waddr(e_wb_waddr), .i_wb_wdata(e_wb_wdata),
      .i_flush(e_flush), .o_dbg_stall(e_stall)
   );

   typedef struct {
      logic        v;
      logic [31:0] ins;
      logic [31:0] pc;
      logic        rdy;
      logic        wbv;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic        fl;
      logic        x_ready;
      logic        x_stall;
      logic        x_valid;
      logic [3:0]  mask;   // [0] pc/opcode/funct3/imm/wen/illegal, [1] rs1, [2] rs2, [3] rd
      logic [31:0] x_pc;
      logic [6:0]  x_op;
      logic [2:0]  x_f3;
      logic [31:0] x_imm;
      logic [31:0] x_rs1;
      logic [31:0] x_rs2;
      logic [4:0]  x_rd;
      logic        x_wen;
   } step_t;

   step_t steps[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // keep=1: the bundle is expected to hold the previous row's decoded fields.
   task automatic add(input logic v, input logic [31:0] ins, input logic rdy, input logic wbv,
                      input logic [4:0] wba, input logic [31:0] wbd, input logic fl,
                      input logic x_ready, input logic x_stall, input logic x_valid,
                      input logic [3:0] mask, input logic [31:0] imm, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [4:0] rd, input logic wen, input logic keep);
      step_t s;
      s.v = v; s.ins = ins; s.pc = 32'h100 + 32'(4 * steps.size()); s.rdy = rdy;
      s.wbv = wbv; s.wba = wba; s.wbd = wbd; s.fl = fl;
      s.x_ready = x_ready; s.x_stall = x_stall; s.x_valid = x_valid;
      if (keep) begin
         step_t p;
         p = steps[steps.size() - 1];
         s.mask = p.mask; s.x_pc = p.x_pc; s.x_op = p.x_op; s.x_f3 = p.x_f3; s.x_imm = p.x_imm;
         s.x_rs1 = p.x_rs1; s.x_rs2 = p.x_rs2; s.x_rd = p.x_rd; s.x_wen = p.x_wen;
      end else begin
         s.mask = mask; s.x_pc = s.pc; s.x_op = ins[6:0]; s.x_f3 = ins[14:12]; s.x_imm = imm;
         s.x_rs1 = r1; s.x_rs2 = r2; s.x_rd = rd; s.x_wen = wen;
      end
      steps.push_back(s);
   endtask

   localparam logic [31:0] ADDI1  = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] ADDI3  = 32'h0010_0193; // addi x3,x0,1
   localparam logic [31:0] ADD4   = 32'h0031_8233; // add  x4,x3,x3
   localparam logic [31:0] SW     = 32'hFE22_AE23; // sw   x2,-4(x5)
   localparam logic [31:0] ADDI7  = 32'h0070_0393; // addi x7,x0,7
   localparam logic [31:0] ADD8   = 32'h0003_8433; // add  x8,x7,x0
   localparam logic [31:0] ADDI9  = 32'h0090_0493; // addi x9,x0,9
   localparam logic [31:0] ADDI10 = 32'h0004_8513; // addi x10,x9,0
   localparam logic [31:0] LUI11  = 32'hABCD_E5B7; // lui  x11,0xABCDE
   localparam logic [31:0] BEQ    = 32'hFE00_0CE3; // beq  x0,x0,-8
   localparam logic [31:0] ADDI13 = 32'h0004_0693; // addi x13,x8,0
   localparam logic [31:0] ADDI2  = 32'h0000_8113; // addi x2,x1,0
   localparam logic [31:0] ADD20  = 32'h0020_8A33; // add  x20,x1,x2
   localparam logic [31:0] ADDI6  = 32'h0002_0313; // addi x6,x4,0
   localparam logic [31:0] ADDI7Z = 32'h0000_0393; // addi x7,x0,0

   initial begin
      rst = 1'b1;
      {if_valid, ex_ready, wb_valid, flush} = '0;
      {if_instr, if_pc, wb_wdata, wb_waddr} = '0;
      {e_if_valid, e_ex_ready, e_wb_valid, e_flush} = '0;
      {e_if_instr, e_if_pc, e_wb_wdata, e_wb_waddr} = '0;

      //   v  instr   rdy wbv wba  wbd      fl  rdy stl val mask     imm           rs1       rs2  rd  wen keep
      add(1, ADDI1,   1,  0,  0,   0,       0,  1,  0,  1,  4'b1011, 32'd5,        0,        0,   1,  1,  0);
      add(0, 0,       1,  1,  1,   32'd5,   0,  1,  0,  0,  4'b0000, 0,            0,        0,   0,  0,  0);
      add(1, ADDI3,   1,  0,  0,   0,       0,  1,  0,  1,  4'b1011, 32'd1,        0,        0,   3,  1,  0);
      add(1, ADD4,    1,  0,  0,   0,       0,  0,  1,  0,  4'b0000, 0,            0,        0,   0,  0,  0);
`ifdef DECODE_WB_BYPASS_EN
      add(1, ADD4,    1,  1,  3,   32'd1,   0,  1,  0,  1,  4'b1111, 0,            32'd1,    32'd1, 4, 1, 0);
`else
      add(1, ADD4,    1,  1,  3,   32'd1,   0,  0,  1,  0,  4'b0000, 0,            0,        0,   0,  0,  0);
      add(1, ADD4,    1,  0,  0,   0,       0,  1,  0,  1,  4'b1111, 0,            32'd1,    32'd1, 4, 1, 0);
`endif
      add(0, 0,       1,  1,  4,   32'd2,   0,  1,  0,  0,  4'b0000, 0,            0,        0,   0,  0,  0);
      add(1, SW,      0,  0,  0,   0,       0,  1,  0,  1,  4'b0111, 32'hFFFFFFFC, 0,        0,   0,  0,  0);
      add(1, ADDI7,   0,  0,  0,   0,       0,  0,  0,  1,  4'b0000, 0,            0,        0,   0,  0,  1);
      add(1, ADDI7,   0,  0,  0,   0,       0,  0,  0,  1,  4'b0000, 0,            0,        0,   0,  0,  1);
      add(1, ADDI7,   0,  0,  0,   0,       0,  0,  0,  1,  4'b0000, 0,            0,        0,   0,  0,  1);
      add(1, ADDI7,   1,  0,  0,   0,       0,  1,  0,  1,  4'b1011, 32'd7,        0,        0,   7,  1,  0);
      add(1, ADD8,    0,  0,  0,   0,       1,  0,  0,  0,  4'b0000, 0,            0,        0,   0,  0,  0);
      add(1, ADD8,    1,  0,  0,   0,       0,  1,  0,  1,  4'b1111, 0,            0,        0,   8,  1,  0);
      add(1, ADDI9,   1,  1,  9,   32'h99,  0,  1,  0,  1,  4'b1011, 32'd9,        0,        0,   9,  1,  0);
      add(1, ADDI10,  1,  0,  0,   0,       0,  0,  1,  0,  4'b0000, 0,            0,        0,   0,  0,  0);
`ifdef DECODE_WB_BYPASS_EN
      add(1, ADDI10,  1,  1,  9,   32'h55,  0,  1,  0,  1,  4'b1011, 0,            32'h55,   0,   10, 1,  0);
`else
      add(1, ADDI10,  1,  1,  9,   32'h55,  0,  0,  1,  0,  4'b0000, 0,            0,        0,   0,  0,  0);
      add(1, ADDI10,  1,  0,  0,   0,       0,  1,  0,  1,  4'b1011, 0,            32'h55,   0,   10, 1,  0);
`endif
      add(1, LUI11,   1,  0,  0,   0,       0,  1,  0,  1,  4'b1001, 32'hABCDE000, 0,        0,   11, 1,  0);
      add(1, BEQ,     1,  0,  0,   0,       0,  1,  0,  1,  4'b0111, 32'hFFFFFFF8, 0,        0,   0,  0,  0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset ex_valid", 32'(ex_valid), 0);
      chk("reset ex_pc", ex_pc, 0);
      chk("reset ex_imm", ex_imm, 0);
      chk("reset rd_wen", 32'(rd_wen), 0);
      chk("reset stall", 32'(stall), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < steps.size(); k++) begin
         @(negedge clk);
         if_valid = steps[k].v;   if_instr = steps[k].ins; if_pc = steps[k].pc;
         ex_ready = steps[k].rdy; wb_valid = steps[k].wbv; wb_waddr = steps[k].wba;
         wb_wdata = steps[k].wbd; flush = steps[k].fl;
         #1;
         chk($sformatf("s%0d if_ready", k), 32'(if_ready), 32'(steps[k].x_ready));
         chk($sformatf("s%0d stall", k), 32'(stall), 32'(steps[k].x_stall));
         @(posedge clk);
         #1;
         chk($sformatf("s%0d ex_valid", k), 32'(ex_valid), 32'(steps[k].x_valid));
         if (steps[k].mask[0]) begin
            chk($sformatf("s%0d ex_pc", k), ex_pc, steps[k].x_pc);
            chk($sformatf("s%0d opcode", k), 32'(ex_opcode), 32'(steps[k].x_op));
            chk($sformatf("s%0d funct3", k), 32'(ex_funct3), 32'(steps[k].x_f3));
            chk($sformatf("s%0d imm", k), ex_imm, steps[k].x_imm);
            chk($sformatf("s%0d rd_wen", k), 32'(rd_wen), 32'(steps[k].x_wen));
            chk($sformatf("s%0d illegal", k), 32'(illegal), 0);
         end
         if (steps[k].mask[1]) chk($sformatf("s%0d rs1", k), rs1_d, steps[k].x_rs1);
         if (steps[k].mask[2]) chk($sformatf("s%0d rs2", k), rs2_d, steps[k].x_rs2);
         if (steps[k].mask[3]) chk($sformatf("s%0d rd", k), 32'(ex_rd), 32'(steps[k].x_rd));
      end

      // Reset while stalled on x8 (never written back) returns to the reset state at once.
      @(negedge clk);
      if_valid = 1'b1; if_instr = ADDI13; ex_ready = 1'b1; wb_valid = 1'b0; flush = 1'b0;
      #1;
      chk("midrst stall before", 32'(stall), 1);
      chk("midrst ready before", 32'(if_ready), 0);
      #1 rst = 1'b1;
      #1;
      chk("midrst ex_valid", 32'(ex_valid), 0);
      chk("midrst ex_imm", ex_imm, 0);
      chk("midrst stall", 32'(stall), 0);
      @(negedge clk);
      rst = 1'b0; if_instr = ADDI2;
      #1;
      chk("postrst ready", 32'(if_ready), 1);
      @(posedge clk);
      #1;
      chk("postrst ex_valid", 32'(ex_valid), 1);
      chk("postrst rs1 cleared", rs1_d, 0);
      @(negedge clk);
      if_valid = 1'b0;

      // RV32E instance: out-of-range rd is illegal and leaves the scoreboard alone; x0 stays 0.
      e_ex_ready = 1'b1;
      e_wb_valid = 1'b1; e_wb_waddr = 5'd0; e_wb_wdata = 32'hDEAD;
      @(negedge clk);
      e_wb_valid = 1'b0;
      e_if_valid = 1'b1; e_if_instr = ADD20;
      #1;
      chk("rv32e add20 ready", 32'(e_if_ready), 1);
      @(posedge clk);
      #1;
      chk("rv32e add20 valid", 32'(e_ex_valid), 1);
      chk("rv32e add20 illegal", 32'(e_illegal), 1);
      @(negedge clk);
      e_if_instr = ADDI6;
      #1;
      chk("rv32e x4 ready", 32'(e_if_ready), 1);
      chk("rv32e x4 stall", 32'(e_stall), 0);
      @(posedge clk);
      #1;
      chk("rv32e x4 illegal", 32'(e_illegal), 0);
      @(negedge clk);
      e_if_instr = ADDI7Z;
      @(posedge clk);
      #1;
      chk("rv32e x0 read", e_rs1_d, 0);
      chk("rv32e x0 valid", 32'(e_ex_valid), 1);
      @(negedge clk);
      e_if_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
